// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encodings and owner codes for the memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  localparam logic ARB_OWNER_CPU = 1'b0;
  localparam logic ARB_OWNER_EXT = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between the CPU and the external loader.
// CPU has priority; a starvation guard forces an EXT grant after STARVE_MAX CPU wins.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int LW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);
  localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [LW-1:0] LAT_LOAD   = LW'(MEM_LAT - 1);

  arb_state_t        state_r;
  logic [LW-1:0]     lat_cnt_r;
  logic [SW-1:0]     starve_cnt_r;
  logic              owner_r;
  logic              we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              mem_read_r;
  logic              mem_write_r;
  logic              busy_r;
  logic              cpu_ack_r;
  logic              ext_ack_r;
  logic [DATA_W-1:0] cpu_rdata_r;
  logic [DATA_W-1:0] ext_rdata_r;

  logic              ext_win_s;
  logic              cpu_win_s;
  logic [SW-1:0]     starve_next_s;
  logic              grant_we_s;
  logic [ADDR_W-1:0] grant_addr_s;
  logic [DATA_W-1:0] grant_wdata_s;
  logic [DATA_W-1:0] resp_data_s;

  // Arbitration, starvation update and grant muxing.
  always_comb begin
    ext_win_s = ext_req && (!cpu_req || (starve_cnt_r == STARVE_TOP));
    cpu_win_s = cpu_req && !ext_win_s;
    if (ext_win_s) begin
      starve_next_s = '0;
    end else if (cpu_win_s && ext_req) begin
      starve_next_s = (starve_cnt_r == STARVE_TOP) ? STARVE_TOP : (starve_cnt_r + SW'(1));
    end else begin
      starve_next_s = '0;
    end
    if (ext_win_s) begin
      grant_we_s    = ext_we;
      grant_addr_s  = ext_addr;
      grant_wdata_s = ext_wdata;
    end else begin
      grant_we_s    = cpu_we;
      grant_addr_s  = cpu_addr;
      grant_wdata_s = cpu_wdata;
    end
    // Writes return the last captured read value rather than fresh memory data.
    if (we_r) begin
      resp_data_s = rdata_r;
    end else begin
      resp_data_s = mem_rdata;
    end
  end

  // Access sequencer with registered memory strobes, acks and read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ARB_IDLE;
      lat_cnt_r    <= '0;
      starve_cnt_r <= '0;
      owner_r      <= ARB_OWNER_CPU;
      we_r         <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      rdata_r      <= '0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      busy_r       <= 1'b0;
      cpu_ack_r    <= 1'b0;
      ext_ack_r    <= 1'b0;
      cpu_rdata_r  <= '0;
      ext_rdata_r  <= '0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          cpu_ack_r   <= 1'b0;
          ext_ack_r   <= 1'b0;
          cpu_rdata_r <= '0;
          ext_rdata_r <= '0;
          if (ext_win_s || cpu_win_s) begin
            owner_r      <= ext_win_s ? ARB_OWNER_EXT : ARB_OWNER_CPU;
            we_r         <= grant_we_s;
            mem_addr_r   <= grant_addr_s;
            mem_wdata_r  <= grant_wdata_s;
            lat_cnt_r    <= LAT_LOAD;
            starve_cnt_r <= starve_next_s;
            mem_read_r   <= !grant_we_s;
            mem_write_r  <= grant_we_s && (MEM_LAT == 1);
            busy_r       <= 1'b1;
            state_r      <= ARB_ACCESS;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ARB_IDLE;
          end
        end
        ARB_ACCESS: begin
          if (lat_cnt_r == '0) begin
            if (!we_r) begin
              rdata_r <= mem_rdata;
            end else begin
              rdata_r <= rdata_r;
            end
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            cpu_ack_r   <= (owner_r == ARB_OWNER_CPU);
            ext_ack_r   <= (owner_r == ARB_OWNER_EXT);
            cpu_rdata_r <= (owner_r == ARB_OWNER_CPU) ? resp_data_s : '0;
            ext_rdata_r <= (owner_r == ARB_OWNER_EXT) ? resp_data_s : '0;
            state_r     <= ARB_RESP;
          end else begin
            lat_cnt_r   <= lat_cnt_r - LW'(1);
            mem_write_r <= we_r && (lat_cnt_r == LW'(1));
            state_r     <= ARB_ACCESS;
          end
        end
        ARB_RESP: begin
          cpu_ack_r   <= 1'b0;
          ext_ack_r   <= 1'b0;
          cpu_rdata_r <= '0;
          ext_rdata_r <= '0;
          busy_r      <= 1'b0;
          state_r     <= ARB_IDLE;
        end
        default: begin
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
          mem_addr_r  <= '0;
          mem_wdata_r <= '0;
          cpu_ack_r   <= 1'b0;
          ext_ack_r   <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ARB_IDLE;
        end
      endcase
    end
  end

  assign cpu_ack   = cpu_ack_r;
  assign cpu_rdata = cpu_rdata_r;
  assign ext_ack   = ext_ack_r;
  assign ext_rdata = ext_rdata_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_read  = mem_read_r;
  assign mem_write = mem_write_r;
  assign busy      = busy_r;
  assign owner     = owner_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=2 instance plus a MEM_LAT=1 instance
// sharing a combinational memory model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [12:0] cpu_addr, ext_addr;
  logic [7:0]  cpu_wdata, ext_wdata;
  logic        cpu_ack, ext_ack, mem_read, mem_write, busy, owner;
  logic [7:0]  cpu_rdata, ext_rdata, mem_wdata, mem_rdata;
  logic [12:0] mem_addr;

  logic        cpu_req1;
  logic [12:0] cpu_addr1;
  logic        cpu_ack1, ext_ack1, mem_read1, mem_write1, busy1, owner1;
  logic [7:0]  cpu_rdata1, ext_rdata1, mem_wdata1, mem_rdata1;
  logic [12:0] mem_addr1;

  logic [7:0]  mem [0:8191];
  int          wr_cnt;
  int          n_asserts;
  int          n_fail;
  int          w0;
  logic [7:0]  ext_pattern;

  mem_port_arbiter #(.ADDR_W(13), .DATA_W(8), .MEM_LAT(2), .STARVE_MAX(3)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.ADDR_W(13), .DATA_W(8), .MEM_LAT(1), .STARVE_MAX(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req1), .cpu_we(1'b0), .cpu_addr(cpu_addr1), .cpu_wdata(8'h00),
    .cpu_ack(cpu_ack1), .cpu_rdata(cpu_rdata1),
    .ext_req(1'b0), .ext_we(1'b0), .ext_addr(13'h0000), .ext_wdata(8'h00),
    .ext_ack(ext_ack1), .ext_rdata(ext_rdata1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_read(mem_read1), .mem_write(mem_write1),
    .mem_rdata(mem_rdata1), .busy(busy1), .owner(owner1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata  = mem_read  ? mem[mem_addr]  : 8'h00;
  assign mem_rdata1 = mem_read1 ? mem[mem_addr1] : 8'h00;

  // Memory contents: preloaded while rst is high, written by the MEM_LAT=2 instance.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
      mem[13'h005] <= 8'hA5;
      mem[13'h000] <= 8'h5A;
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_asserts = 0; n_fail = 0; wr_cnt = 0;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 13'h0000; cpu_wdata = 8'h00;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = 13'h0000; ext_wdata = 8'h00;
    cpu_req1 = 1'b0; cpu_addr1 = 13'h0000;
    tick(2);
    chk("rst_outputs", {cpu_ack, ext_ack, mem_read, mem_write, busy, owner}, 32'h0);
    chk("rst_buses", {mem_addr, mem_wdata, cpu_rdata}, 32'h0);
    chk("rst_outputs1", {cpu_ack1, mem_read1, busy1, owner1, mem_addr1}, 32'h0);
    rst = 1'b0;
    tick(1);

    // CPU read of 0x005
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h005;
    tick(1);
    chk("t1_c1_read", {mem_read, mem_write, busy, owner}, 32'b1010);
    chk("t1_c1_addr", mem_addr, 32'h005);
    tick(1);
    chk("t1_c2_read", mem_read, 32'h1);
    chk("t1_c2_ack", cpu_ack, 32'h0);
    tick(1);
    chk("t1_c3_ack", {cpu_ack, ext_ack, mem_read}, 32'b100);
    chk("t1_c3_rdata", cpu_rdata, 32'hA5);
    cpu_req = 1'b0;
    tick(1);
    chk("t1_c4_idle", {cpu_ack, busy, cpu_rdata}, 32'h0);

    // EXT write 0x3C to 0x1FF
    w0 = wr_cnt;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 13'h1FF; ext_wdata = 8'h3C;
    tick(1);
    chk("t2_c1", {mem_write, mem_read, owner, busy}, 32'b0011);
    chk("t2_c1_addr", mem_addr, 32'h1FF);
    tick(1);
    chk("t2_c2_write", mem_write, 32'h1);
    chk("t2_c2_bus", {mem_addr, mem_wdata}, {19'h0, 13'h1FF, 8'h3C} & 32'h1FFFFF);
    tick(1);
    chk("t2_c3_ack", {ext_ack, cpu_ack, mem_write}, 32'b100);
    chk("t2_c3_addr_idle", mem_addr, 32'h0);
    chk("t2_mem", mem[13'h1FF], 32'h3C);
    chk("t2_one_pulse", wr_cnt - w0, 32'h1);
    ext_req = 1'b0; ext_we = 1'b0;
    tick(1);

    // Both requesting continuously: CPU x3 then forced EXT, repeated
    ext_pattern = 8'b1000_1000;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h005;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 13'h1FF;
    for (int i = 0; i < 8; i++) begin
      tick((i == 0) ? 3 : 4);
      chk($sformatf("t3_grant%0d", i), {cpu_ack, ext_ack}, {30'h0, !ext_pattern[i], ext_pattern[i]});
    end
    cpu_req = 1'b0; ext_req = 1'b0;
    tick(1);

    // Reset during the first ACCESS cycle of a CPU write
    w0 = wr_cnt;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h010; cpu_wdata = 8'h77;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 13'h1FF;
    tick(1);
    chk("t4_pre_busy", {busy, owner, mem_write}, 32'b100);
    rst = 1'b1;
    #1;
    chk("t4_async_clear", {cpu_ack, ext_ack, mem_read, mem_write, busy, owner}, 32'h0);
    chk("t4_async_bus", {mem_addr, mem_wdata}, 32'h0);
    tick(2);
    chk("t4_no_write", wr_cnt - w0, 32'h0);
    chk("t4_no_ack", cpu_ack, 32'h0);
    rst = 1'b0;
    // starve_cnt must restart at 0: three CPU grants before EXT
    for (int i = 0; i < 4; i++) begin
      tick((i == 0) ? 3 : 4);
      chk($sformatf("t4_grant%0d", i), {cpu_ack, ext_ack}, (i == 3) ? 32'b01 : 32'b10);
    end
    cpu_req = 1'b0; ext_req = 1'b0; cpu_we = 1'b0;
    chk("t4_writes_after", wr_cnt - w0, 32'h3);
    chk("t4_mem", mem[13'h010], 32'h77);
    tick(1);

    // CPU pulse during a busy EXT read; EXT drops req after grant
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 13'h005;
    tick(1);
    ext_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h000;
    tick(1);
    cpu_req = 1'b0;
    tick(1);
    chk("t5_ext_ack", {ext_ack, cpu_ack}, 32'b10);
    chk("t5_ext_rdata", ext_rdata, 32'hA5);
    tick(1);
    chk("t5_idle1", {busy, mem_read, cpu_ack}, 32'h0);
    tick(1);
    chk("t5_idle2", {busy, mem_read, cpu_ack, ext_ack}, 32'h0);

    // MEM_LAT = 1 instance, CPU read of 0x000
    cpu_req1 = 1'b1; cpu_addr1 = 13'h000;
    tick(1);
    chk("t6_c1", {mem_read1, cpu_ack1, busy1}, 32'b101);
    tick(1);
    chk("t6_c2", {mem_read1, cpu_ack1, ext_ack1}, 32'b010);
    chk("t6_rdata", cpu_rdata1, 32'h5A);
    cpu_req1 = 1'b0;
    tick(1);
    chk("t6_c3", {cpu_ack1, busy1, cpu_rdata1}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
